// File: rtl/serial_logic16.sv
// Bit-serial 16-bit logic unit (NOT/AND/OR/NAND), one result bit per cycle, LSB first.
// Latency: 16 bit_valid cycles after start, done plus the parallel result one cycle later; start is ignored while busy.
module serial_logic16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        done,
    output logic [15:0] out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  op_q;
    logic [15:0] shift;
    logic        res_bit;

    always_comb begin
        res_bit = 1'b0;
        case (op_q)
            2'b00:   res_bit = ~a_q[count];
            2'b01:   res_bit = a_q[count] & b_q[count];
            2'b10:   res_bit = a_q[count] | b_q[count];
            default: res_bit = ~(a_q[count] & b_q[count]);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            a_q       <= 16'd0;
            b_q       <= 16'd0;
            op_q      <= 2'd0;
            shift     <= 16'd0;
            out       <= 16'd0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done      <= 1'b0;
            bit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        count <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Shifting in from the MSB end leaves bit k at position k after 16 cycles.
                    bit_out   <= res_bit;
                    bit_valid <= 1'b1;
                    shift     <= {res_bit, shift[15:1]};
                    count     <= count + 4'd1;
                    if (count == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    out   <= shift;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
